winograd_split_8x10_3x3x4x4: RTL

- Inverse of the tile-to-image transform: cuts an 8x10 image of 32-bit words into a 3x3 grid of overlapping 4x4 tiles for the Winograd input stage.
- Pixels arrive as a row-major stream and are buffered in full.
- The nine tiles are then emitted one per handshake on a wide tile bus.
- Sits between the matrix loader and the Winograd input transform.

---
 rtl/winograd_split_8x10_3x3x4x4.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/winograd_split_8x10_3x3x4x4.sv
// Buffers an 8x10 row-major image and emits the nine overlapping 4x4 Winograd input tiles.
// Define SPLIT_COLUMN_MAJOR_EN to emit tiles in column-major grid order instead of row-major.
module winograd_split_8x10_3x3x4x4 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_ROWS   = 8,
  parameter int IMG_COLS   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [16*DATA_WIDTH-1:0] m_tile,
  output logic [1:0]               m_tile_row,
  output logic [1:0]               m_tile_col,
  output logic                     m_last,
  output logic                     busy
);

  localparam int NPIX = IMG_ROWS * IMG_COLS;
  localparam int TW   = 16 * DATA_WIDTH;
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [DATA_WIDTH-1:0] pix_mem_q [NPIX];
  logic [0:0]  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  ti_q, ti_d, tj_q, tj_d;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [TW-1:0] m_tile_q, m_tile_d;

  logic [1:0]  nxt_ti, nxt_tj, sel_ti, sel_tj;
  logic [6:0]  pidx;
  logic [TW-1:0] tile_view;
  logic        accept;
  logic        pix_we;

  assign accept = s_valid && s_ready_q;

  // Grid position that follows the tile currently on the bus.
  always_comb begin
`ifdef SPLIT_COLUMN_MAJOR_EN
    if (ti_q == 2'd2) begin
      nxt_ti = 2'd0;
      nxt_tj = tj_q + 2'd1;
    end else begin
      nxt_ti = ti_q + 2'd1;
      nxt_tj = tj_q;
    end
`else
    if (tj_q == 2'd2) begin
      nxt_tj = 2'd0;
      nxt_ti = ti_q + 2'd1;
    end else begin
      nxt_tj = tj_q + 2'd1;
      nxt_ti = ti_q;
    end
`endif
  end

  // While loading, the first tile (0,0) is staged; it never touches the final pixel.
  assign sel_ti = (state_q == ST_EMIT) ? nxt_ti : 2'd0;
  assign sel_tj = (state_q == ST_EMIT) ? nxt_tj : 2'd0;

  always_comb begin
    tile_view = '0;
    pidx      = '0;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 4; l++) begin
        pidx = 7'((2 * int'(sel_ti) + k) * IMG_COLS + 3 * int'(sel_tj) + l);
        tile_view[(k*4+l)*DATA_WIDTH +: DATA_WIDTH] = pix_mem_q[pidx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ti_d      = ti_q;
    tj_d      = tj_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_tile_d  = m_tile_q;
    pix_we    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          pix_we = 1'b1;
          if (cnt_q == 7'(NPIX - 1)) begin
            cnt_d     = '0;
            state_d   = ST_EMIT;
            ti_d      = 2'd0;
            tj_d      = 2'd0;
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            m_tile_d  = tile_view;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: begin
        if (m_valid_q && m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = ST_LOAD;
          end else begin
            ti_d     = nxt_ti;
            tj_d     = nxt_tj;
            m_tile_d = tile_view;
            m_last_d = (nxt_ti == 2'd2) && (nxt_tj == 2'd2);
          end
        end
      end
    endcase
    s_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (pix_we) pix_mem_q[cnt_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      ti_q      <= '0;
      tj_q      <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_tile_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ti_q      <= ti_d;
      tj_q      <= tj_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_tile_q  <= m_tile_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_tile     = m_tile_q;
  assign m_tile_row = ti_q;
  assign m_tile_col = tj_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q == ST_EMIT);

endmodule
